// File: rtl/seq_detector_non_overlap_if.sv
// Serial-line bundle for the "101" detector: input bit plus the detector's observable outputs.
// master drives the serial bit; slave is the detector.
interface seq_detector_non_overlap_if;
  logic       seq_in;
  logic       detected;
  logic [1:0] state_out;

  modport master (
    output seq_in,
    input  detected,
    input  state_out
  );

  modport slave (
    input  seq_in,
    output detected,
    output state_out
  );
endinterface

// File: rtl/seq_detector_non_overlap.sv
// Non-overlapping Moore detector for the serial pattern "101".
// detected is registered alongside the state so it never sees seq_in combinationally.
module seq_detector_non_overlap (
  input  logic                        clk,
  input  logic                        reset_n,  // active-high despite the name
  seq_detector_non_overlap_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StS1   = 2'b01,
    StS10  = 2'b10,
    StS101 = 2'b11
  } state_e;

  state_e state_d, state_q;
  logic   detected_d, detected_q;

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: state_d = bus.seq_in ? StS1   : StIdle;
      StS1:   state_d = bus.seq_in ? StS1   : StS10;
      StS10:  state_d = bus.seq_in ? StS101 : StIdle;
      // A 0 after a match restarts from scratch: the trailing 1 is not reused.
      StS101: state_d = bus.seq_in ? StS1   : StIdle;
      default: state_d = StIdle;
    endcase
    detected_d = (state_d == StS101);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= StIdle;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      detected_q <= detected_d;
    end
  end

  assign bus.detected  = detected_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_seq_detector_non_overlap.sv
// Self-checking bench for seq_detector_non_overlap: directed sequences, async reset, and random
// stream checked against a history-based model of non-overlapping "101" detection.
module tb_seq_detector_non_overlap;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  seq_detector_non_overlap_if bus ();

  seq_detector_non_overlap dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bits seen since the last match or reset; a match consumes the history.
  bit       hist[$];
  bit       m_det;
  bit [1:0] m_state;

  task automatic model_step(input bit b);
    int n;
    hist.push_back(b);
    n = hist.size();
    m_det = 1'b0;
    if (n >= 3 && hist[n-3] == 1'b1 && hist[n-2] == 1'b0 && hist[n-1] == 1'b1) begin
      m_det   = 1'b1;
      m_state = 2'd3;
      hist.delete();
    end else if (n >= 2 && hist[n-2] == 1'b1 && hist[n-1] == 1'b0) begin
      m_state = 2'd2;
    end else if (n >= 1 && hist[n-1] == 1'b1) begin
      m_state = 2'd1;
    end else begin
      m_state = 2'd0;
    end
  endtask

  task automatic drive_bit(input bit b);
    @(negedge clk);
    bus.seq_in = b;
    @(posedge clk);
    #1;
    model_step(b);
  endtask

  task automatic test_reset();
    reset_n    = 1'b1;
    bus.seq_in = 1'b0;
    #1;
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.detected !== 1'b0)
      $display("FAIL reset_asserted: state_out=%b detected=%b, want 00/0", bus.state_out,
               bus.detected);
    else n_pass++;
    #1.5;
    reset_n = 1'b0;
    #0.5;
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.detected !== 1'b0)
      $display("FAIL reset_released: state_out=%b detected=%b, want 00/0", bus.state_out,
               bus.detected);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.detected !== 1'b0)
      $display("FAIL reset_first_edge: state_out=%b detected=%b, want 00/0", bus.state_out,
               bus.detected);
    else n_pass++;
    hist.delete();
  endtask

  task automatic test_directed(input string name, input bit bits[$], input bit [1:0] exp[$]);
    for (int i = 0; i < bits.size(); i++) begin
      drive_bit(bits[i]);
      n_checks++;
      if (bus.state_out !== exp[i])
        $display("FAIL %s_state[%0d]: state_out=%b, want %b", name, i, bus.state_out, exp[i]);
      else n_pass++;
      n_checks++;
      if (bus.detected !== (exp[i] == 2'b11))
        $display("FAIL %s_det[%0d]: detected=%b, want %b", name, i, bus.detected,
                 exp[i] == 2'b11);
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    test_directed("stream",
                  '{0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1},
                  '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00,
                    2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11});
  endtask

  task automatic test_back_to_back();
    test_directed("b2b", '{1, 0, 1, 1, 0, 1},
                  '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11});
  endtask

  task automatic test_no_overlap();
    test_directed("noovl", '{1, 0, 1, 0, 1},
                  '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01});
  endtask

  task automatic test_async_reset();
    test_directed("pre_rst", '{1, 0}, '{2'b01, 2'b10});
    #2;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.detected !== 1'b0)
      $display("FAIL async_reset_mid: state_out=%b detected=%b, want 00/0", bus.state_out,
               bus.detected);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.state_out !== 2'b00)
      $display("FAIL async_reset_hold: state_out=%b, want 00", bus.state_out);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    hist.delete();
    test_directed("post_rst", '{1}, '{2'b01});
  endtask

  task automatic test_random();
    bit prev_det;
    prev_det = bus.detected;
    for (int i = 0; i < 25; i++) begin
      drive_bit(i < 15 ? bit'($urandom_range(1, 0)) : 1'b0);
      n_checks++;
      if (bus.state_out !== m_state || bus.detected !== m_det)
        $display("FAIL rand[%0d]: state_out=%b detected=%b, want %b/%b", i, bus.state_out,
                 bus.detected, m_state, m_det);
      else n_pass++;
      n_checks++;
      if (prev_det && bus.detected)
        $display("FAIL rand_consec[%0d]: detected=1 two cycles running, want single pulse", i);
      else n_pass++;
      prev_det = bus.detected;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_no_overlap();
    test_async_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_non_overlap.md
Name: seq_detector_non_overlap

Overview:
- Serial bit-stream detector for the pattern "101", one bit per clock on seq_in.
- Non-overlapping: once a match completes, its bits are not reused as the start of the next match.
- Moore machine: detected depends only on the registered state. The current state is exported on state_out for debug and observation.
- Sits directly on a serial input line; no handshake.

Parameters:
- None. Pattern "101" and state encoding are fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-high reset (asserted when 1, despite the _n suffix); forces IDLE immediately
- seq_in  input  1  serial data bit, sampled on each rising clk edge
- detected  output  1  high while FSM is in S101 (pattern just completed)
- state_out  output  2  current state register value

Behaviour:
- One clock; reset is asynchronous and active-high. reset_n=1 forces state to IDLE without waiting for clk, so detected=0 and state_out=2'b00 immediately. The release of reset is synchronous to the next clk edge.
- State encoding, fixed:
  - IDLE=2'b00
  - S1=2'b01 (seen "1")
  - S10=2'b10 (seen "10")
  - S101=2'b11 (match)
- Transitions on rising clk, with next state given as seq_in=0 / seq_in=1:
  - IDLE: 0 -> IDLE, 1 -> S1
  - S1: 0 -> S10, 1 -> S1
  - S10: 0 -> IDLE, 1 -> S101
  - S101: 0 -> IDLE, 1 -> S1
- Non-overlap rule: from S101 a 0 returns to IDLE, never to S10. The trailing "1" of a match does not count toward the next "101".
- Outputs:
  - detected = (state == S101), registered-state decode, no combinational path from seq_in.
  - state_out = state register.
- Latency: detected rises in the cycle after the edge that samples the final "1". It stays high for exactly one cycle unless the FSM re-enters S101.
- Back-to-back matches: a new match can only complete from S101 through S1 and S10, so the earliest next assertion is 3 cycles after the previous one.
- Unknown or undriven seq_in: the design must not latch X into state while reset is asserted.
- The next-state default branch returns to IDLE, so there is no lockup.
- Reset mid-sequence: any partial match is discarded. After reset releases, a full "101" is required again.

Test Plan:
- Assert reset_n=1 for 2.5 ns, then release -> state_out=00 and detected=0 during reset and until the first "1" is sampled.
- Drive 0,0,1,1,0,0,0,1,0,1,0,1,0,1 (one bit per edge):
  - required state sequence: 00,00,01,01,10,00,00,01,10,11,00,01,10,11
  - detected is high exactly in the 10th and 14th states
  - detected is not high after the 12th bit (overlap would fire there)
- Drive 1,0,1,1,0,1 -> detected pulses after the 3rd bit and after the 6th bit. The 1 following S101 goes to S1, then 0 to S10, then 1 to S101.
- Drive 1,0,1,0,1 -> only one detection. The second "101" shares the middle "1" and is rejected (state goes S101 -> IDLE -> S1).
- Drive 1,0 (state S10), then assert reset_n asynchronously between clock edges -> state_out=00 and detected=0 before the next edge. After release, a single bit 1 gives S1, not S101.
- Drive 15 random bits followed by 10 idle cycles -> detected matches a reference model implementing the transition table exactly, and is never high for two consecutive cycles.
